// File: rtl/secuenciador_tonos_pkg.sv
// Shared types and defaults for the tone sequencer.
package pkg_tonos;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CARGA   = 2'd1,
    SONANDO = 2'd2
  } estado_t;

  // Width of the sine generator's phase-increment word
  localparam int JUMP_W    = 7;
  localparam int DUR_W_DEF = 16;
  localparam int PRESC_DEF = 50000;

endpackage

// File: rtl/secuenciador_tonos_if.sv
// Control/programming bus between user logic and the tone sequencer.
interface secuenciador_tonos_if
  import pkg_tonos::*;
#(
  parameter int N_NOTAS = 16,
  parameter int DUR_W   = DUR_W_DEF
);
  localparam int IW = $clog2(N_NOTAS);

  logic              wr_en;
  logic [IW-1:0]     wr_addr;
  logic [JUMP_W-1:0] wr_jump;
  logic [DUR_W-1:0]  wr_dur;
  logic              start;
  logic              stop;
  logic              loop;
  logic [JUMP_W-1:0] jump;
  logic              activo;
  logic [IW-1:0]     nota_idx;
  logic              fin;

  modport master (
    output wr_en, wr_addr, wr_jump, wr_dur, start, stop, loop,
    input  jump, activo, nota_idx, fin
  );

  modport slave (
    input  wr_en, wr_addr, wr_jump, wr_dur, start, stop, loop,
    output jump, activo, nota_idx, fin
  );
endinterface

// File: rtl/secuenciador_tonos_divisor_tick.sv
// Duration-tick prescaler: one-cycle tick every PRESC clocks after clr drops.
module divisor_tick
  import pkg_tonos::*;
#(
  parameter int PRESC = PRESC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(PRESC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next prescaler count; tick is registered so it coincides with count == PRESC-1
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == ULTIMO) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    tick_d = (cnt_d == ULTIMO);
  end

  // Prescaler registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/secuenciador_tonos.sv
// Tone sequencer: plays a (jump, duration) table into the sine generator.
module secuenciador_tonos
  import pkg_tonos::*;
#(
  parameter int N_NOTAS = 16,
  parameter int DUR_W   = DUR_W_DEF,
  parameter int PRESC   = PRESC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  secuenciador_tonos_if.slave  bus
);
  localparam int IW = $clog2(N_NOTAS);

  logic [JUMP_W-1:0] tab_jump_q [N_NOTAS];
  logic [DUR_W-1:0]  tab_dur_q  [N_NOTAS];

  estado_t           estado_q, estado_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              wrap_q, wrap_d;      // idx reached 0 by wrapping: end of sequence
  logic [DUR_W-1:0]  dur_q, dur_d;        // latched so table writes don't disturb the note
  logic [DUR_W-1:0]  cnt_q, cnt_d;        // ticks elapsed in the current note
  logic [JUMP_W-1:0] jump_q, jump_d;
  logic              activo_q, activo_d;
  logic              fin_q, fin_d;

  logic [JUMP_W-1:0] ent_jump_s;
  logic [DUR_W-1:0]  ent_dur_s;
  logic              tick_s;
  logic              clr_s;

  assign ent_jump_s = tab_jump_q[idx_q];
  assign ent_dur_s  = tab_dur_q[idx_q];
  assign clr_s      = (estado_q != SONANDO);

  divisor_tick #(.PRESC(PRESC)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // Note table: writable in any state, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_NOTAS; i++) begin
        tab_jump_q[i] <= '0;
        tab_dur_q[i]  <= '0;
      end
    end else if (bus.wr_en) begin
      tab_jump_q[bus.wr_addr] <= bus.wr_jump;
      tab_dur_q[bus.wr_addr]  <= bus.wr_dur;
    end
  end

  // Next-state and next-output logic; stop overrides everything
  always_comb begin
    estado_d = estado_q;
    idx_d    = idx_q;
    wrap_d   = wrap_q;
    dur_d    = dur_q;
    cnt_d    = cnt_q;
    jump_d   = jump_q;
    fin_d    = 1'b0;
    if (bus.stop) begin
      estado_d = IDLE;
      idx_d    = '0;
      wrap_d   = 1'b0;
      cnt_d    = '0;
      jump_d   = '0;
    end else begin
      case (estado_q)
        IDLE: begin
          idx_d  = '0;
          wrap_d = 1'b0;
          cnt_d  = '0;
          jump_d = '0;
          if (bus.start) begin
            estado_d = CARGA;
          end else begin
            estado_d = IDLE;
          end
        end
        CARGA: begin
          cnt_d = '0;
          if (wrap_q || (ent_dur_s == '0)) begin
            wrap_d = 1'b0;
            idx_d  = '0;
            // Entry 0 with dur=0 never restarts, avoiding a zero-length loop
            if (bus.loop && (wrap_q || (idx_q != '0))) begin
              estado_d = CARGA;
            end else begin
              estado_d = IDLE;
              jump_d   = '0;
              fin_d    = 1'b1;
            end
          end else begin
            estado_d = SONANDO;
            jump_d   = ent_jump_s;
            dur_d    = ent_dur_s;
          end
        end
        SONANDO: begin
          if (tick_s) begin
            if (cnt_q == (dur_q - DUR_W'(1))) begin
              estado_d = CARGA;
              idx_d    = idx_q + IW'(1);
              wrap_d   = (idx_q == IW'(N_NOTAS - 1));
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + DUR_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          estado_d = IDLE;
          idx_d    = '0;
          wrap_d   = 1'b0;
          cnt_d    = '0;
          jump_d   = '0;
        end
      endcase
    end
    activo_d = (estado_d != IDLE);
  end

  // FSM and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= IDLE;
      idx_q    <= '0;
      wrap_q   <= 1'b0;
      dur_q    <= '0;
      cnt_q    <= '0;
      jump_q   <= '0;
      activo_q <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      wrap_q   <= wrap_d;
      dur_q    <= dur_d;
      cnt_q    <= cnt_d;
      jump_q   <= jump_d;
      activo_q <= activo_d;
      fin_q    <= fin_d;
    end
  end

  assign bus.jump     = jump_q;
  assign bus.activo   = activo_q;
  assign bus.nota_idx = idx_q;
  assign bus.fin      = fin_q;

endmodule

// File: tb/tb_secuenciador_tonos.sv
// Directed self-checking bench for secuenciador_tonos (N_NOTAS=4, PRESC=4).
module tb_secuenciador_tonos;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int PR = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  secuenciador_tonos_if #(.N_NOTAS(N), .DUR_W(DW)) bus ();

  secuenciador_tonos #(.N_NOTAS(N), .DUR_W(DW), .PRESC(PR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int k, input int ej, input int ea, input int en, input int ef);
    chk({tag, ".jump"},     k, 32'(bus.jump),     ej);
    chk({tag, ".activo"},   k, 32'(bus.activo),   ea);
    chk({tag, ".nota_idx"}, k, 32'(bus.nota_idx), en);
    chk({tag, ".fin"},      k, 32'(bus.fin),      ef);
  endtask

  task automatic wr(input int a, input int j, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 2'(a);
    bus.wr_jump = 7'(j);
    bus.wr_dur  = 16'(d);
    step();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    int ej, ea, en, ef, o, p, n, off;
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_jump = '0;
    bus.wr_dur  = '0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.loop    = 1'b0;
    step();
    step();
    chk_out("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();

    // Basic sequence: {0:(10,2), 1:(20,3), 2:(0,0)}
    wr(0, 10, 2);
    wr(1, 20, 3);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      ej = (k <= 1) ? 0 : (k <= 10) ? 10 : (k <= 23) ? 20 : 0;
      ea = (k <= 23) ? 1 : 0;
      en = (k <= 9) ? 0 : (k <= 22) ? 1 : (k == 23) ? 2 : 0;
      ef = (k == 24) ? 1 : 0;
      chk_out("basic", k, ej, ea, en, ef);
      step();
    end

    // Looping, loop cleared during the second pass
    bus.loop  = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      if (k >= 47) begin
        chk_out("loop", k, 0, 0, 0, (k == 47) ? 1 : 0);
      end else begin
        p  = (k <= 23) ? 0 : 1;
        o  = (p == 0) ? k - 1 : k - 24;
        ej = (o == 0) ? ((p == 0) ? 0 : 20) : (o <= 9) ? 10 : 20;
        en = (o <= 8) ? 0 : (o <= 21) ? 1 : 2;
        chk_out("loop", k, ej, 1, en, 0);
      end
      if (k == 40) bus.loop = 1'b0;
      step();
    end

    // Write entry 1 = (33,1) while entry 1 sounds; then stop mid-note
    bus.loop  = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      ea = 1;
      ef = 0;
      if (k <= 23) begin
        o  = k - 1;
        ej = (o == 0) ? 0 : (o <= 9) ? 10 : 20;
        en = (o <= 8) ? 0 : (o <= 21) ? 1 : 2;
      end else if (k == 24) begin
        ej = 20; en = 0;
      end else if (k <= 32) begin
        ej = 10; en = 0;
      end else if (k == 33) begin
        ej = 10; en = 1;
      end else if (k <= 37) begin
        ej = 33; en = 1;
      end else if (k == 38) begin
        ej = 33; en = 2;
      end else if (k == 39) begin
        ej = 33; en = 0;
      end else if (k <= 42) begin
        ej = 10; en = 0;
      end else begin
        ej = 0; en = 0; ea = 0;
      end
      chk_out("wrplay", k, ej, ea, en, ef);
      if (k == 12) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd1;
        bus.wr_jump = 7'd33;
        bus.wr_dur  = 16'd1;
      end
      if (k == 13) bus.wr_en = 1'b0;
      if (k == 42) bus.stop = 1'b1;
      if (k == 43) begin
        bus.stop = 1'b0;
        bus.loop = 1'b0;
      end
      step();
    end

    // Stop sampled at T+5
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 5) begin
        chk_out("stop", k, (k == 1) ? 0 : 10, 1, 0, 0);
      end else begin
        chk_out("stop", k, 0, 0, 0, 0);
      end
      if (k == 5) bus.stop = 1'b1;
      if (k == 6) bus.stop = 1'b0;
      step();
    end

    // Simultaneous start and stop in IDLE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    chk_out("startstop", 1, 0, 0, 0, 0);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    step();
    chk_out("startstop", 2, 0, 0, 0, 0);

    // Full table with dur=1 and index wrap
    wr(0, 5, 1);
    wr(1, 6, 1);
    wr(2, 7, 1);
    wr(3, 8, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      if (k >= 22) begin
        chk_out("full", k, 0, 0, 0, (k == 22) ? 1 : 0);
      end else if (k == 21) begin
        chk_out("full", k, 8, 1, 0, 0);
      end else begin
        n   = (k - 1) / 5;
        off = (k - 1) % 5;
        ej  = (off == 0) ? ((n == 0) ? 0 : 4 + n) : 5 + n;
        chk_out("full", k, ej, 1, n, 0);
      end
      step();
    end

    // Reset mid-note, then entry 0 with dur=0 and loop=1
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk_out("prerst", 3, 5, 1, 0, 0);
    rst = 1'b1;
    step();
    chk_out("rst", 1, 0, 0, 0, 0);
    rst = 1'b0;
    step();
    bus.loop  = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_out("zero", 1, 0, 1, 0, 0);
    step();
    chk_out("zero", 2, 0, 0, 0, 1);
    step();
    chk_out("zero", 3, 0, 0, 0, 0);
    bus.loop = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/secuenciador_tonos.md
# secuenciador_tonos

Tone sequencer that drives the `jump` (phase-increment) input of the quarter-wave sine generator. It plays a programmable table of (jump, duration) entries, one after another, with start/stop control, optional looping and an end-of-sequence pulse. It sits between the user/control logic and the sine generator, and is the only block that writes the generator's frequency word.

## Interface
- `N_NOTAS`, 16: table depth (power of 2); `IW = log2(N_NOTAS)`.
- `DUR_W`, 16: width of the duration field, in ticks.
- `PRESC`, 50000: clk cycles per duration tick (≥ 2).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: table write strobe.
- `wr_addr` in IW: table entry to write.
- `wr_jump` in 7: phase increment for the entry.
- `wr_dur` in DUR_W: entry duration in ticks. 0 marks end of sequence.
- `start` in 1: begin playback at entry 0. Level-sampled, acted on only in IDLE.
- `stop` in 1: abort playback.
- `loop` in 1: sampled at end of sequence. 1 means restart at entry 0.
- `jump` out 7: registered frequency word to the sine generator. 0 means silence.
- `activo` out 1: high while in CARGA or SONANDO.
- `nota_idx` out IW: index of the entry currently loaded or playing.
- `fin` out 1: one-cycle pulse on natural end of sequence (not on stop).

## Operation
- **Table**: N_NOTAS × (7 + DUR_W) registers.
  - Write on `wr_en` at the clk edge, in any state.
  - A write to the entry being played does not affect the note in progress. It takes effect the next time that entry is loaded.
- **FSM states**: IDLE, CARGA, SONANDO.
- **IDLE**
  - `jump`=0, `activo`=0, `nota_idx`=0.
  - `start`=1 and `stop`=0 → CARGA with idx=0.
- **CARGA** (exactly 1 cycle): read entry idx.
  - If dur≠0 → SONANDO, and `jump` takes the entry's jump.
  - If dur=0 or idx wrapped past N_NOTAS−1 (end of sequence):
    - `loop`=1 and idx≠0 → CARGA again with idx=0.
    - Otherwise → IDLE with `fin`=1.
  - Entry 0 with dur=0 always ends, even with `loop`=1. This prevents a zero-length infinite loop.
  - `jump` holds the previous note's value during CARGA, so there is no glitch to silence between notes.
- **SONANDO**
  - On entry, the tick prescaler and the tick counter are cleared.
  - A tick is issued when the prescaler reaches PRESC−1.
  - After dur ticks → CARGA with idx+1. Index arithmetic is modulo N_NOTAS; wrap to 0 counts as end of sequence.
- **stop**: `stop`=1 in any state → IDLE next cycle, with `jump`=0, `activo`=0 and no `fin`. `stop` wins over a simultaneous `start`.
- **start while busy**: `start` in CARGA or SONANDO is ignored.
- **Reset**:
  - State returns to IDLE.
  - All outputs go to 0; `fin`=0.
  - Prescaler and counters go to 0.
  - All table entries go to 0: jump 0, dur 0.
  - Reset mid-note silences the output on the next cycle.
  - Reset has priority over `wr_en`, `start` and `stop`.

## Timing
- All outputs are registered.
- Latency from `start` sampled at edge T:
  - `activo`=1 from T+1 (CARGA).
  - The first note's `jump` is valid from T+2.
- Each note drives `jump` for exactly dur×PRESC cycles. It then holds for 1 CARGA cycle before the next value appears.
- End of sequence: `fin`=1 for the single cycle in which the FSM is back in IDLE, coincident with `jump`=0 and `activo`=0.
- The loop restart costs 1 extra CARGA cycle: the end-detect cycle plus the load of entry 0.
- `nota_idx` updates on entry to CARGA.

## Structure
Shared package `pkg_tonos`:
- FSM state enum: IDLE, CARGA, SONANDO.
- `JUMP_W`=7.
- Default DUR_W and PRESC.

Sub-module `divisor_tick`:
- Parameter PRESC.
- Inputs `clk`, `rst`, `clr`; output `tick`.
- One-cycle `tick` every PRESC cycles after `clr`.

The FSM, table and duration counter live in `secuenciador_tonos`.

## Test plan
All scenarios use PRESC=4, N_NOTAS=4.
- **Basic sequence.** Setup: table {0:(10,2), 1:(20,3), 2:(x,0)}; `start` at T.
  - `jump`=10 for T+2..T+9.
  - `jump`=10 held at T+10 (CARGA).
  - `jump`=20 for T+11..T+22.
  - `fin`=1 with `jump`=0 at T+24; `activo` low from T+24.
- **Looping.** Same table with `loop`=1.
  - After the entry-1 note, `jump` returns to 10 at T+25.
  - No `fin` pulse.
  - Clearing `loop` mid-sequence → `fin` at the next end.
- **Stop mid-note.** `stop` at T+5.
  - `jump`=0 and `activo`=0 at T+6; `fin` never asserted.
  - Simultaneous `start`+`stop` in IDLE → stays IDLE.
- **Full table and wrap.** All 4 entries have dur=1.
  - 4 notes of 4 cycles each, then the end of sequence.
  - `nota_idx` sequence 0,1,2,3.
- **Write during play.** Write entry 1 = (33,1) while entry 1 is sounding with jump 20.
  - The current note stays 20 for its full length.
  - On the next loop pass, entry 1 plays 33 for 4 cycles.
- **Reset and zero entries.**
  - `rst` mid-note → all outputs 0 on the next cycle.
  - `start` with entry 0 dur=0 and `loop`=1 → `fin`=1 at T+2, `jump` stays 0.
